// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register word offsets,
// FSM state encoding and STAT bit positions.
package irq_ctrl_pkg;

  localparam logic [1:0] IC_MASK = 2'd0;
  localparam logic [1:0] IC_MODE = 2'd1;
  localparam logic [1:0] IC_PEND = 2'd2;
  localparam logic [1:0] IC_STAT = 2'd3;

  localparam int IC_STAT_INSVC = 31;

  typedef enum logic {
    IC_IDLE    = 1'b0,
    IC_SERVICE = 1'b1
  } ic_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational, zero latency.
// Produces {vld, id}. id is 0 when no request is set.
module irq_prio_enc #(
  parameter int N    = 6,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    req,
  output logic            vld,
  output logic [ID_W-1:0] id
);

  // Walk from the top so the lowest set index is the last one written.
  always_comb begin
    vld = 1'b0;
    id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        id  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: edge/level capture, mask, fixed priority,
// single in-service slot. IRQ follows a src edge by one cycle; ack/EOI have no backpressure.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] src,
  input  logic             ack,
  output logic             IRQ,
  output logic [ID_W-1:0]  irq_id
);

  ic_state_e        state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic [ID_W-1:0]  isr_id_q, isr_id_d;

  logic [1:0]       reg_sel;
  logic             wr_mask, wr_mode, wr_pend, wr_stat;
  logic [N_SRC-1:0] req, rise, w1c, ack_clr;
  logic             req_vld, take;
  logic [ID_W-1:0]  winner;
  logic             unused_bits;

  assign reg_sel     = Addr[3:2];
  assign wr_mask     = WE && (reg_sel == IC_MASK);
  assign wr_mode     = WE && (reg_sel == IC_MODE);
  assign wr_pend     = WE && (reg_sel == IC_PEND);
  assign wr_stat     = WE && (reg_sel == IC_STAT);
  assign unused_bits = ^{Addr[31:4], Din[31:N_SRC]};

  assign req  = pend_q & mask_q;
  assign take = (state_q == IC_IDLE) && ack && req_vld;

  irq_prio_enc #(.N(N_SRC), .ID_W(ID_W)) u_prio (
    .req (req),
    .vld (req_vld),
    .id  (winner)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IC_IDLE;
      mask_q   <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      src_q    <= '0;
      isr_id_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      src_q    <= src_d;
      isr_id_q <= isr_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IC_IDLE:    if (take)    state_d = IC_SERVICE;
      IC_SERVICE: if (wr_stat) state_d = IC_IDLE;
      default:                 state_d = IC_IDLE;
    endcase
  end

  // Register datapath. Edge bits: a new rising edge beats any same-cycle clear.
  always_comb begin
    mask_d   = wr_mask ? Din[N_SRC-1:0] : mask_q;
    mode_d   = wr_mode ? Din[N_SRC-1:0] : mode_q;
    src_d    = src;
    isr_id_d = take ? winner : isr_id_q;
    rise     = src & ~src_q;
    w1c      = wr_pend ? Din[N_SRC-1:0] : '0;
    ack_clr  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_clr[i] = take && (winner == ID_W'(i));
    end
    pend_d = (mode_q & (rise | (pend_q & ~w1c & ~ack_clr))) | (~mode_q & src);
  end

  always_comb begin
    IRQ    = (state_q == IC_IDLE) && req_vld;
    irq_id = (state_q == IC_IDLE) ? winner : isr_id_q;
    Dout   = '0;
    case (reg_sel)
      IC_MASK: Dout = 32'(mask_q);
      IC_MODE: Dout = 32'(mode_q);
      IC_PEND: Dout = 32'(pend_q);
      IC_STAT: begin
        Dout[IC_STAT_INSVC] = (state_q == IC_SERVICE);
        Dout[ID_W-1:0]      = isr_id_q;
      end
      default: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: inputs change and outputs are sampled mid-cycle
// (after the falling edge); expected values are hand-computed constants.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N_SRC = 6;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [31:2]      Addr;
  logic             WE;
  logic [31:0]      Din;
  logic [31:0]      Dout;
  logic [N_SRC-1:0] src;
  logic             ack;
  logic             IRQ;
  logic [ID_W-1:0]  irq_id;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rv;

  irq_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .src     (src),
    .ack     (ack),
    .IRQ     (IRQ),
    .irq_id  (irq_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr      = '0;
    Addr[3:2] = a;
    Din       = d;
    WE        = 1'b1;
    tick();
    WE        = 1'b0;
    Din       = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr      = '0;
    Addr[3:2] = a;
    #1;
    d = Dout;
  endtask

  initial begin
    reset_n = 1'b0;
    WE      = 1'b0;
    Addr    = '0;
    Din     = '0;
    src     = '0;
    ack     = 1'b0;
    @(negedge clk);
    @(negedge clk);

    chk("rst_irq", 32'(IRQ), 32'h0);
    chk("rst_irq_id", 32'(irq_id), 32'h0);
    rd(IC_MASK, rv); chk("rst_mask", rv, 32'h0);
    rd(IC_MODE, rv); chk("rst_mode", rv, 32'h0);
    tick();
    rd(IC_PEND, rv); chk("rst_pend", rv, 32'h0);
    rd(IC_STAT, rv); chk("rst_stat", rv, 32'h0);
    reset_n = 1'b1;
    tick();

    // single edge source through ack and EOI
    wr(IC_MASK, 32'h01);
    wr(IC_MODE, 32'h01);
    src = 6'b000001;
    tick();
    src = '0;
    chk("t1_irq", 32'(IRQ), 32'h1);
    chk("t1_irq_id", 32'(irq_id), 32'h0);
    rd(IC_PEND, rv); chk("t1_pend", rv, 32'h01);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t1_irq_svc", 32'(IRQ), 32'h0);
    rd(IC_STAT, rv); chk("t1_stat_svc", rv, 32'h8000_0000);
    rd(IC_PEND, rv); chk("t1_pend_acked", rv, 32'h0);
    wr(IC_STAT, 32'h0);
    chk("t1_irq_eoi", 32'(IRQ), 32'h0);
    rd(IC_STAT, rv); chk("t1_stat_eoi", rv, 32'h0);

    // two simultaneous edges: lower index first, the other after EOI
    wr(IC_MASK, 32'h3F);
    wr(IC_MODE, 32'h3F);
    src = 6'b010010;
    tick();
    src = '0;
    chk("t2_irq", 32'(IRQ), 32'h1);
    chk("t2_irq_id", 32'(irq_id), 32'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t2_irq_svc", 32'(IRQ), 32'h0);
    chk("t2_irq_id_svc", 32'(irq_id), 32'h1);
    wr(IC_STAT, 32'h0);
    chk("t2_irq_reassert", 32'(IRQ), 32'h1);
    chk("t2_irq_id_next", 32'(irq_id), 32'h4);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    wr(IC_STAT, 32'h0);
    rd(IC_PEND, rv); chk("t2_pend_empty", rv, 32'h0);

    // level mode: request follows the line, late ack is spurious
    wr(IC_MODE, 32'h00);
    wr(IC_MASK, 32'h04);
    src = 6'b000100;
    tick();
    chk("t3_irq", 32'(IRQ), 32'h1);
    chk("t3_irq_id", 32'(irq_id), 32'h2);
    src = '0;
    tick();
    rd(IC_PEND, rv); chk("t3_pend_drop", rv, 32'h0);
    chk("t3_irq_drop", 32'(IRQ), 32'h0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    rd(IC_STAT, rv); chk("t3_spurious_insvc", 32'(rv[31]), 32'h0);
    chk("t3_spurious_irq", 32'(IRQ), 32'h0);

    // edge set beats same-cycle write-1-to-clear
    wr(IC_MODE, 32'h3F);
    wr(IC_MASK, 32'h01);
    src       = 6'b000001;
    Addr      = '0;
    Addr[3:2] = IC_PEND;
    Din       = 32'h01;
    WE        = 1'b1;
    tick();
    WE        = 1'b0;
    Din       = '0;
    rd(IC_PEND, rv); chk("t4_set_wins", rv, 32'h01);
    wr(IC_PEND, 32'h01);
    rd(IC_PEND, rv); chk("t4_w1c", rv, 32'h0);
    chk("t4_irq", 32'(IRQ), 32'h0);
    src = '0;
    tick();

    // new higher-priority edge while servicing id 3
    wr(IC_MASK, 32'h3F);
    src = 6'b001000;
    tick();
    src = '0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    rd(IC_STAT, rv); chk("t5_stat", rv, 32'h8000_0003);
    chk("t5_irq_id_svc", 32'(irq_id), 32'h3);
    src = 6'b000001;
    tick();
    src = '0;
    chk("t5_irq_masked", 32'(IRQ), 32'h0);
    rd(IC_PEND, rv); chk("t5_pend_accum", rv, 32'h01);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    rd(IC_STAT, rv); chk("t5_ack_in_svc", rv, 32'h8000_0003);
    wr(IC_STAT, 32'h0);
    chk("t5_irq_eoi", 32'(IRQ), 32'h1);
    chk("t5_irq_id_eoi", 32'(irq_id), 32'h0);

    // MASK write alongside ack: ack sees the old mask
    Addr      = '0;
    Addr[3:2] = IC_MASK;
    Din       = 32'h0;
    WE        = 1'b1;
    ack       = 1'b1;
    tick();
    WE        = 1'b0;
    ack       = 1'b0;
    rd(IC_STAT, rv); chk("t6_stat", rv, 32'h8000_0000);
    rd(IC_MASK, rv); chk("t6_mask", rv, 32'h0);
    rd(IC_PEND, rv); chk("t6_pend", rv, 32'h0);

    // asynchronous reset in the middle of service
    wr(IC_MASK, 32'h3F);
    src = 6'b100000;
    tick();
    src = '0;
    rd(IC_PEND, rv); chk("t7_pend_pre", rv, 32'h20);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t7_irq_rst", 32'(IRQ), 32'h0);
    rd(IC_STAT, rv); chk("t7_stat_rst", rv, 32'h0);
    rd(IC_MASK, rv); chk("t7_mask_rst", rv, 32'h0);
    @(negedge clk);
    rd(IC_PEND, rv); chk("t7_pend_rst", rv, 32'h0);
    chk("t7_irq_id_rst", 32'(irq_id), 32'h0);
    reset_n = 1'b1;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    rd(IC_STAT, rv); chk("t7_ack_after_rst", rv, 32'h0);
    chk("t7_irq_after_rst", 32'(IRQ), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
